spi_controller: RTL and testbench
=================================

// Module: spi_controller
// PURPOSE
//   SPI mode-0 controller (initiator) that writes the peripheral's 16-bit register frames.
//   Accepts one {write, addr[6:0], data[7:0]} request at a time and serialises it MSB first on ncs/sclk/copi.
//   Captures cipo into rdata for read-back.
//   Sits on the host/test side and drives the 3-wire SPI input of the register-file peripheral.
// PARAMETERS
//   DIV       4  clk cycles per sclk half-period (low and high); legal >= 3
//   CS_SETUP  4  clk cycles from ncs fall to first sclk rise window start; legal >= 3
//   CS_HOLD   4  clk cycles from last sclk fall to ncs rise; legal >= 3
//   IDLE_GAP  4  clk cycles ncs held high after a frame before the next accept; legal >= 1
// PORTS
//   clk        in   1  clock; the only clock
//   rst        in   1  reset: synchronous, active-high
//   req_valid  in   1  request present
//   req_ready  out  1  controller can accept; a transfer occurs on valid&&ready
//   req_write  in   1  frame bit 15 (1 = write)
//   req_addr   in   7  frame bits 14:8
//   req_data   in   8  frame bits 7:0
//   busy       out  1  high from the accept cycle +1 until return to IDLE
//   done       out  1  one-cycle pulse in the cycle ncs returns high
//   rdata      out  8  last 8 cipo bits of the completed frame; valid when done=1, held until next done
//   cipo       in   1  serial data from the peripheral (sampled on sclk rise)
//   sclk       out  1  SPI clock, idle low
//   copi       out  1  serial data to the peripheral
//   ncs        out  1  chip select, active low
// BEHAVIOUR
//   Reset values (sync, active-high): ncs=1, sclk=0, copi=0, done=0, busy=0, rdata=0; state=IDLE.
//   req_ready is 1 only in IDLE and only when rst=0.
//   All SPI outputs are driven straight from flops (no combinational paths to pins).
//   State IDLE
//     - On accept (cycle T0): latch frame={req_write,req_addr,req_data}.
//     - At T0+1: ncs=0, copi=frame[15], sclk=0, busy=1; go to SETUP.
//   State SETUP
//     - Hold for CS_SETUP cycles with sclk=0; then go to SHIFT at bit 15.
//   State SHIFT (16 bits, i=15..0), each bit is 2*DIV cycles:
//     - DIV cycles sclk=0 with copi=frame[i] stable.
//     - Then DIV cycles sclk=1.
//     - On the cycle sclk goes 1: shift cipo into rx.
//     - At the end of the high phase, sclk returns to 0 and copi takes frame[i-1] in the same cycle.
//     - After bit 0's high phase: sclk=0, copi=0, go to HOLD.
//   State HOLD
//     - ncs stays 0 for CS_HOLD cycles.
//     - Then ncs=1, done=1 for one cycle, rdata=rx[7:0]; go to GAP.
//   State GAP
//     - ncs=1 for IDLE_GAP cycles; then IDLE, busy=0, req_ready=1.
//   Timing
//     - ncs low time is exactly CS_SETUP + 32*DIV + CS_HOLD cycles.
//     - Exactly 16 sclk rising edges per frame.
//     - Accept-to-done latency: 1 + CS_SETUP + 32*DIV + CS_HOLD cycles.
//   Boundary conditions
//     - req_valid while busy is ignored; the request is not consumed and is accepted in a later IDLE cycle.
//     - Back-to-back requests (valid held high) are separated by >= IDLE_GAP ncs-high cycles.
//     - req_write=0 still shifts all 16 bits unchanged.
//     - Request fields may change after the accept cycle without affecting the frame in flight.
//     - rst during any state: next cycle ncs=1, sclk=0, copi=0, no done, rdata unchanged-to-0 (reset value).
//       The partial frame is abandoned; the peripheral discards it because its bit count is not 16.
//     - Illegal parameter values halt elaboration via a generate-time $error.
// TESTING
//   1. Reset: rst=1 for 3 cycles -> ncs=1, sclk=0, copi=0, req_ready=1 after release.
//   2. Write 0x84A5 (w=1, addr=0x04, data=0xA5), defaults
//      -> ncs low 136 cycles, 16 sclk rises, copi bits 1000_0100_1010_0101, done at T0+137.
//   3. Loopback cipo=copi, frame 0x03C3 -> rdata=0xC3 at done; busy drops IDLE_GAP cycles later.
//   4. req_valid held high with two frames 0x8001 then 0x8102
//      -> second ncs fall >= IDLE_GAP+1 cycles after first done; both frames correct.
//   5. rst asserted at the 9th sclk rise -> ncs=1/sclk=0 next cycle, no done, req_ready=1 after release.
//   6. DIV=3, CS_SETUP=3 against the peripheral model -> addr 0x00..0x04 written with 0x11..0x55, read back correct.

Source files
------------

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: serialises one 16-bit {write, addr, data} frame MSB first
// on ncs/sclk/copi and returns the last 8 cipo bits of the frame in rdata.
module spi_controller #(
   parameter int DIV      = 4,
   parameter int CS_SETUP = 4,
   parameter int CS_HOLD  = 4,
   parameter int IDLE_GAP = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [6:0] req_addr,
   input  logic [7:0] req_data,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   input  logic       cipo,
   output logic       sclk,
   output logic       copi,
   output logic       ncs
);

   if (DIV < 3) begin : g_bad_div
      $error("spi_controller: DIV must be >= 3");
   end
   if (CS_SETUP < 3) begin : g_bad_setup
      $error("spi_controller: CS_SETUP must be >= 3");
   end
   if (CS_HOLD < 3) begin : g_bad_hold
      $error("spi_controller: CS_HOLD must be >= 3");
   end
   if (IDLE_GAP < 1) begin : g_bad_gap
      $error("spi_controller: IDLE_GAP must be >= 1");
   end

   localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
   localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
   localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
   localparam logic [15:0] GAP_LAST   = 16'(IDLE_GAP - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t      state;
   logic [15:0] cnt;
   logic [3:0]  bit_idx;
   logic [14:0] frame;   // bit 15 goes straight to copi on accept, so only 14:0 is kept
   logic [7:0]  rx;

   always_comb begin
      req_ready = 1'b0;
      if (state == IDLE && !rst) req_ready = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         frame   <= '0;
         rx      <= '0;
         ncs     <= 1'b1;
         sclk    <= 1'b0;
         copi    <= 1'b0;
         done    <= 1'b0;
         busy    <= 1'b0;
         rdata   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  frame <= {req_addr, req_data};
                  ncs   <= 1'b0;
                  copi  <= req_write;
                  sclk  <= 1'b0;
                  busy  <= 1'b1;
                  cnt   <= '0;
                  state <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == SETUP_LAST) begin
                  cnt     <= '0;
                  bit_idx <= 4'd15;
                  state   <= SHIFT;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            SHIFT: begin
               // each half-period is DIV cycles; the sclk level tells which half we are in
               if (cnt != DIV_LAST) begin
                  cnt <= cnt + 16'd1;
               end else begin
                  cnt <= '0;
                  if (!sclk) begin
                     sclk <= 1'b1;
                     rx   <= {rx[6:0], cipo};
                  end else begin
                     sclk <= 1'b0;
                     if (bit_idx == 4'd0) begin
                        copi  <= 1'b0;
                        state <= HOLD;
                     end else begin
                        copi    <= frame[bit_idx - 4'd1];
                        bit_idx <= bit_idx - 4'd1;
                     end
                  end
               end
            end
            HOLD: begin
               if (cnt == HOLD_LAST) begin
                  cnt   <= '0;
                  ncs   <= 1'b1;
                  done  <= 1'b1;
                  rdata <= rx;
                  state <= GAP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench: instance 0 (defaults, cipo looped back) and instance 1
// (DIV=3, CS_SETUP=3) talking to a behavioural register-file peripheral.
module tb_spi_controller;

   localparam int GAP  = 4;
   localparam int LOW0 = 4 + 32 * 4 + 4;
   localparam int LOW1 = 3 + 32 * 3 + 4;

   typedef struct packed {
      logic [15:0] frame;
      logic [7:0]  rd;
   } exp_t;

   logic       clk = 1'b0;
   logic [1:0] rst = 2'b11;
   logic [1:0] req_valid = '0;
   logic [1:0] req_ready;
   logic [1:0] req_write = '0;
   logic [6:0] req_addr [2];
   logic [7:0] req_data [2];
   logic [1:0] busy, done, sclk, copi, ncs;
   logic [7:0] rdata [2];
   logic       cipo_lb;
   logic       cipo_p = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   bit mon_en = 1'b0;
   bit [1:0] abort = '0;

   exp_t q0[$], q1[$];
   int   aq0[$], aq1[$];
   logic [7:0] ref_mem [128];

   always #5 clk = ~clk;

   assign cipo_lb = copi[0];

   spi_controller dut0 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_write(req_write[0]), .req_addr(req_addr[0]), .req_data(req_data[0]),
      .busy(busy[0]), .done(done[0]), .rdata(rdata[0]), .cipo(cipo_lb),
      .sclk(sclk[0]), .copi(copi[0]), .ncs(ncs[0])
   );

   spi_controller #(.DIV(3), .CS_SETUP(3)) dut1 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_write(req_write[1]), .req_addr(req_addr[1]), .req_data(req_data[1]),
      .busy(busy[1]), .done(done[1]), .rdata(rdata[1]), .cipo(cipo_p),
      .sclk(sclk[1]), .copi(copi[1]), .ncs(ncs[1])
   );

   // peripheral: shifts frames in on sclk rise, answers reads in the data byte,
   // commits writes only when exactly 16 bits arrived before ncs rises
   logic [15:0] p_sh = '0;
   logic [7:0]  p_tx = '0;
   logic [7:0]  p_mem [128];
   int          p_cnt = 0;

   always @(negedge ncs[1]) p_cnt = 0;
   always @(posedge sclk[1]) begin
      p_sh  = {p_sh[14:0], copi[1]};
      p_cnt = p_cnt + 1;
   end
   always @(negedge sclk[1]) begin
      if (p_cnt == 8) begin
         p_tx   = p_sh[7] ? 8'h00 : p_mem[p_sh[6:0]];
         cipo_p = p_tx[7];
      end else if (p_cnt > 8 && p_cnt < 16) begin
         p_tx   = {p_tx[6:0], 1'b0};
         cipo_p = p_tx[7];
      end
   end
   always @(posedge ncs[1]) begin
      if (p_cnt == 16 && p_sh[15]) p_mem[p_sh[14:8]] = p_sh[7:0];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor / scoreboard
   logic [1:0]  prev_ncs = '1, prev_sclk = '0, prev_busy = '0, rst_prev = '0;
   int          low_cnt [2], rises [2], last_done [2];
   logic [15:0] cap [2];
   logic [7:0]  held [2];

   initial begin
      for (int g = 0; g < 2; g++) begin
         low_cnt[g] = 0; rises[g] = 0; last_done[g] = -1; cap[g] = '0; held[g] = '0;
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (mon_en) begin
         for (int g = 0; g < 2; g++) begin
            exp_t e;
            int   a;
            int   low_len;
            e = '0;
            a = 0;
            low_len = (g == 0) ? LOW0 : LOW1;
            if (req_valid[g] && req_ready[g]) begin
               if (g == 0) aq0.push_back(cyc); else aq1.push_back(cyc);
            end
            if (!ncs[g] && prev_ncs[g]) begin
               low_cnt[g] = 1; rises[g] = 0; cap[g] = '0;
               if (last_done[g] >= 0) begin
                  n_cmp++;
                  if (cyc - last_done[g] < GAP + 1) begin
                     n_err++;
                     $display("FAIL gap_before_frame[%0d]: got %0d cycles, need >= %0d", g, cyc - last_done[g], GAP + 1);
                  end
               end
            end else if (!ncs[g]) begin
               low_cnt[g]++;
            end
            if (!ncs[g] && sclk[g] && !prev_sclk[g]) begin
               cap[g] = {cap[g][14:0], copi[g]};
               rises[g]++;
            end
            if (ncs[g]) begin
               chk($sformatf("sclk_idle[%0d]", g), 32'(sclk[g]), 0);
               chk($sformatf("copi_idle[%0d]", g), 32'(copi[g]), 0);
            end
            if (ncs[g] && !prev_ncs[g]) begin
               if (abort[g]) begin
                  abort[g] = 1'b0;
                  chk($sformatf("abort_no_done[%0d]", g), 32'(done[g]), 0);
                  if (g == 0 && aq0.size() > 0) void'(aq0.pop_front());
                  if (g == 1 && aq1.size() > 0) void'(aq1.pop_front());
                  last_done[g] = -1;
               end else begin
                  chk($sformatf("frame_expected[%0d]", g), 32'((g == 0) ? q0.size() : q1.size()) != 0 ? 1 : 0, 1);
                  if (g == 0 && q0.size() > 0) e = q0.pop_front();
                  if (g == 1 && q1.size() > 0) e = q1.pop_front();
                  if (g == 0 && aq0.size() > 0) a = aq0.pop_front();
                  if (g == 1 && aq1.size() > 0) a = aq1.pop_front();
                  chk($sformatf("frame_bits[%0d]", g), 32'(cap[g]), 32'(e.frame));
                  chk($sformatf("sclk_rises[%0d]", g), rises[g], 16);
                  chk($sformatf("ncs_low_len[%0d]", g), low_cnt[g], low_len);
                  chk($sformatf("done_at_ncs_rise[%0d]", g), 32'(done[g]), 1);
                  chk($sformatf("rdata[%0d]", g), 32'(rdata[g]), 32'(e.rd));
                  chk($sformatf("latency[%0d]", g), cyc - a, low_len + 1);
                  last_done[g] = cyc;
               end
            end else if (done[g]) begin
               chk($sformatf("stray_done[%0d]", g), 32'(done[g]), 0);
            end
            if (!done[g]) chk($sformatf("rdata_hold[%0d]", g), 32'(rdata[g]), rst_prev[g] ? 0 : 32'(held[g]));
            held[g] = rdata[g];
            if (busy[g] && !prev_busy[g]) chk($sformatf("busy_with_ncs[%0d]", g), 32'(ncs[g]), 0);
            if (!busy[g] && prev_busy[g] && last_done[g] >= 0)
               chk($sformatf("busy_drop[%0d]", g), cyc - last_done[g], GAP);
            prev_ncs[g]  = ncs[g];
            prev_sclk[g] = sclk[g];
            prev_busy[g] = busy[g];
            rst_prev[g]  = rst[g];
         end
      end
   end

   task automatic send(input int g, input logic w, input logic [6:0] a, input logic [7:0] d,
                       input bit keep, input bit push);
      exp_t e;
      bit   ok;
      e.frame = {w, a, d};
      e.rd    = (g == 0) ? d : (w ? 8'h00 : ref_mem[a]);
      if (g == 1 && w) ref_mem[a] = d;
      if (push) begin
         if (g == 0) q0.push_back(e); else q1.push_back(e);
      end
      req_valid[g] = 1'b1;
      req_write[g] = w;
      req_addr[g]  = a;
      req_data[g]  = d;
      ok = 1'b0;
      for (int k = 0; k < 4000 && !ok; k++) begin
         @(negedge clk);
         if (req_ready[g]) ok = 1'b1;
      end
      chk($sformatf("accept_timeout[%0d]", g), 32'(ok), 1);
      @(posedge clk);
      #1;
      if (!keep) begin
         req_valid[g] = 1'b0;
         req_write[g] = 1'($urandom);
         req_addr[g]  = 7'($urandom);
         req_data[g]  = 8'($urandom);
      end
   endtask

   task automatic wait_idle(input int g);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 4000 && !ok; k++) begin
         @(negedge clk);
         if (!busy[g] && ((g == 0) ? q0.size() : q1.size()) == 0) ok = 1'b1;
      end
      chk($sformatf("idle_timeout[%0d]", g), 32'(ok), 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cnt;
      bit  p, k;
      for (int i = 0; i < 128; i++) begin
         p_mem[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
      for (int g = 0; g < 2; g++) begin
         req_addr[g] = '0;
         req_data[g] = '0;
      end

      // reset
      rst = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
         chk("reset_ncs", 32'(ncs[g]), 1);
         chk("reset_sclk", 32'(sclk[g]), 0);
         chk("reset_copi", 32'(copi[g]), 0);
         chk("reset_busy", 32'(busy[g]), 0);
         chk("reset_done", 32'(done[g]), 0);
         chk("reset_rdata", 32'(rdata[g]), 0);
         chk("ready_in_reset", 32'(req_ready[g]), 0);
      end
      rst = 2'b00;
      mon_en = 1'b1;
      @(negedge clk);
      chk("ready_after_reset0", 32'(req_ready[0]), 1);
      chk("ready_after_reset1", 32'(req_ready[1]), 1);
      @(posedge clk);
      #1;

      // single write, then loopback read-style frame, then held-valid back-to-back pair
      send(0, 1'b1, 7'h04, 8'hA5, 1'b0, 1'b1);
      wait_idle(0);
      send(0, 1'b0, 7'h03, 8'hC3, 1'b0, 1'b1);
      wait_idle(0);
      send(0, 1'b1, 7'h00, 8'h01, 1'b1, 1'b1);
      send(0, 1'b1, 7'h01, 8'h02, 1'b0, 1'b1);
      wait_idle(0);

      // reset at the 9th sclk rise abandons the frame
      send(0, 1'b1, 7'($urandom), 8'($urandom), 1'b0, 1'b0);
      cnt = 0;
      p = sclk[0];
      for (int j = 0; j < 2000 && cnt < 9; j++) begin
         @(posedge clk);
         #1;
         if (sclk[0] && !p) cnt++;
         p = sclk[0];
      end
      chk("ninth_rise_seen", cnt, 9);
      abort[0] = 1'b1;
      rst[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_ncs", 32'(ncs[0]), 1);
      chk("abort_sclk", 32'(sclk[0]), 0);
      chk("abort_copi", 32'(copi[0]), 0);
      chk("abort_done", 32'(done[0]), 0);
      chk("abort_rdata", 32'(rdata[0]), 0);
      rst[0] = 1'b0;
      @(negedge clk);
      chk("abort_ready", 32'(req_ready[0]), 1);
      @(posedge clk);
      #1;

      // randomized frames, some back-to-back with valid held
      for (int i = 0; i < 20; i++) begin
         k = (i != 19) && ($urandom_range(0, 1) == 1);
         send(0, 1'($urandom), 7'($urandom), 8'($urandom), k, 1'b1);
         if (!k) repeat ($urandom_range(0, 10)) begin @(posedge clk); #1; end
      end
      wait_idle(0);

      // instance 1 against the register-file peripheral
      for (int i = 0; i < 5; i++) send(1, 1'b1, 7'(i), 8'((i + 1) * 17), 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) send(1, 1'b0, 7'(i), 8'($urandom), 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) send(1, 1'($urandom), 7'($urandom_range(0, 7)), 8'($urandom), 1'b0, 1'b1);
      wait_idle(1);

      repeat (10) @(posedge clk);
      chk("queue0_drained", q0.size(), 0);
      chk("queue1_drained", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
